// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: registered initiator for a combinational ALU.
// A command is accepted over cmd_valid/cmd_ready and its operands are driven
// into the ALU. They are held for SETTLE cycles, then y and the flags are
// captured and returned over rsp_valid/rsp_ready.
// Optional feature: define ALU_SEQ_STICKY_EN to add sticky_clr/sticky_flags.
// These accumulate the captured flags with OR until they are cleared.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// HOLD  | ALU inputs held stable while the result settles
// RESP  | captured result offered on rsp_*, waiting for rsp_ready
module alu_cmd_sequencer #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_cin,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  input  logic             alu_negative,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic [3:0]       rsp_flags,
  output logic             busy
`ifdef ALU_SEQ_STICKY_EN
  ,
  input  logic             sticky_clr,
  output logic [3:0]       sticky_flags
`endif
);

  typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

  // Counter value on the last HOLD cycle; SETTLE is limited to 1..15
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic       load;
  logic       capture;

  // State register; asynchronous reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid)                 state_nxt = HOLD;
      HOLD:    if (settle_cnt == SETTLE_LAST) state_nxt = RESP;
      RESP:    if (rsp_ready)                 state_nxt = IDLE;
      default:                                state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs, plus the datapath strobes
  always_comb begin
    cmd_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
    load      = (state == IDLE) && cmd_valid;
    capture   = (state == HOLD) && (settle_cnt == SETTLE_LAST);
  end

  // ALU operand registers; they keep the last command until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
    end else if (load) begin
      alu_opcode <= cmd_opcode;
      alu_a      <= cmd_a;
      alu_b      <= cmd_b;
      alu_cin    <= cmd_cin;
    end
  end

  // Settle counter: cleared on accept, counts up through HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (load) begin
      settle_cnt <= '0;
    end else if (state == HOLD) begin
      settle_cnt <= settle_cnt + 4'd1;
    end
  end

  // Result capture; the value is held through RESP until it is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_y     <= '0;
      rsp_flags <= '0;
    end else if (capture) begin
      rsp_y     <= alu_y;
      rsp_flags <= {alu_cout, alu_overflow, alu_negative, alu_zero};
    end
  end

`ifdef ALU_SEQ_STICKY_EN
  // Sticky flag accumulator; a clear on the capture edge discards that capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= '0;
    end else if (sticky_clr) begin
      sticky_flags <= '0;
    end else if (capture) begin
      sticky_flags <= sticky_flags | {alu_cout, alu_overflow, alu_negative, alu_zero};
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer (WIDTH=4, SETTLE=2) with a behavioural ALU attached.
// A transaction-level model predicts the outputs and is compared every cycle;
// directed tests pin literal values. Sticky checks need ALU_SEQ_STICKY_EN.
module tb_alu_cmd_sequencer;
  localparam int WIDTH  = 4;
  localparam int SETTLE = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_opcode = '0;
  logic [WIDTH-1:0] cmd_a = '0;
  logic [WIDTH-1:0] cmd_b = '0;
  logic             cmd_cin = 1'b0;
  logic [3:0]       alu_opcode;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_y;
  logic             alu_cout, alu_overflow, alu_negative, alu_zero;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_y;
  logic [3:0]       rsp_flags;
  logic             busy;
`ifdef ALU_SEQ_STICKY_EN
  logic             sticky_clr = 1'b0;
  logic [3:0]       sticky_flags;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [3:0] log_y[$];
  int         log_c[$];

  alu_cmd_sequencer #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags), .busy(busy)
`ifdef ALU_SEQ_STICKY_EN
    , .sticky_clr(sticky_clr), .sticky_flags(sticky_flags)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Attached ALU: returns {y, cout, overflow, negative, zero}; sub reports borrow as cout
  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic cin);
    logic [4:0] r;
    logic [3:0] y;
    logic c, v;
    r = '0; y = a; c = 1'b0; v = 1'b0;
    case (op)
      4'h0: begin
        r = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        y = r[3:0]; c = r[4]; v = (a[3] == b[3]) && (y[3] != a[3]);
      end
      4'h1: begin
        r = {1'b0, a} - {1'b0, b} - {4'b0, cin};
        y = r[3:0]; c = r[4]; v = (a[3] != b[3]) && (y[3] != a[3]);
      end
      4'h2: y = 4'($signed(a) >>> b[1:0]);
      4'h3: y = a & b;
      4'h4: y = a | b;
      4'h5: y = a ^ b;
      default: y = a;
    endcase
    return {y, c, v, y[3], (y == 4'h0)};
  endfunction

  always_comb {alu_y, alu_cout, alu_overflow, alu_negative, alu_zero} =
    alu_fn(alu_opcode, alu_a, alu_b, alu_cin);

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Transaction model: idle -> wait SETTLE edges -> respond until consumed
  logic       m_idle, m_resp;
  int         m_wait;
  logic [3:0] m_op, m_a, m_b, m_y, m_f;
  logic       m_cin;
  logic [7:0] m_r;
  logic       m_cap;
  logic [3:0] m_sticky;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle = 1'b1; m_resp = 1'b0; m_wait = 0;
      m_op = '0; m_a = '0; m_b = '0; m_cin = 1'b0; m_y = '0; m_f = '0;
      m_sticky = '0;
    end else begin
      m_cap = 1'b0;
      if (m_idle) begin
        if (cmd_valid) begin
          m_op = cmd_opcode; m_a = cmd_a; m_b = cmd_b; m_cin = cmd_cin;
          m_idle = 1'b0; m_wait = SETTLE;
        end
      end else if (!m_resp) begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          m_r = alu_fn(m_op, m_a, m_b, m_cin);
          m_y = m_r[7:4]; m_f = m_r[3:0];
          m_resp = 1'b1; m_cap = 1'b1;
        end
      end else if (rsp_ready) begin
        m_resp = 1'b0; m_idle = 1'b1;
      end
`ifdef ALU_SEQ_STICKY_EN
      if (sticky_clr) m_sticky = '0;
      else if (m_cap) m_sticky = m_sticky | m_f;
`endif
    end
  end

  // Per-cycle comparison against the model, plus a log of delivered responses
  always @(negedge clk) begin
    chk(alu_opcode == m_op, "alu_opcode", 32'(alu_opcode), 32'(m_op));
    chk(alu_a == m_a, "alu_a", 32'(alu_a), 32'(m_a));
    chk(alu_b == m_b, "alu_b", 32'(alu_b), 32'(m_b));
    chk(alu_cin == m_cin, "alu_cin", 32'(alu_cin), 32'(m_cin));
    chk(cmd_ready == m_idle, "cmd_ready", 32'(cmd_ready), 32'(m_idle));
    chk(busy == !m_idle, "busy", 32'(busy), 32'(!m_idle));
    chk(rsp_valid == m_resp, "rsp_valid", 32'(rsp_valid), 32'(m_resp));
    if (m_resp) begin
      chk(rsp_y == m_y, "rsp_y", 32'(rsp_y), 32'(m_y));
      chk(rsp_flags == m_f, "rsp_flags", 32'(rsp_flags), 32'(m_f));
    end
`ifdef ALU_SEQ_STICKY_EN
    chk(sticky_flags == m_sticky, "sticky_flags", 32'(sticky_flags), 32'(m_sticky));
`endif
    if (rsp_valid && rsp_ready) begin
      log_y.push_back(rsp_y);
      log_c.push_back(cyc);
    end
  end

  // Issue one command from IDLE, hold the response for 'hold' cycles, then consume it
  task automatic do_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic cin, input int hold,
                        input logic [3:0] exp_y, input logic [3:0] exp_f);
    int n;
    @(negedge clk);
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_cin = cin;
    cmd_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      chk(cmd_ready == 1'b0, "ready_low_hold", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    chk(n < 20, "rsp_timeout", 32'(n), 32'd20);
    chk(rsp_y == exp_y, "cmd_y", 32'(rsp_y), 32'(exp_y));
    chk(rsp_flags == exp_f, "cmd_flags", 32'(rsp_flags), 32'(exp_f));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk(rsp_valid == 1'b1, "hold_valid", 32'(rsp_valid), 32'd1);
      chk(rsp_y == exp_y, "hold_y", 32'(rsp_y), 32'(exp_y));
      chk(cmd_ready == 1'b0, "hold_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk(cmd_ready == 1'b1, "ready_after_rsp", 32'(cmd_ready), 32'd1);
    chk(rsp_valid == 1'b0, "valid_after_rsp", 32'(rsp_valid), 32'd0);
  endtask

  logic [3:0] tp_op[3] = '{4'h0, 4'h1, 4'h2};
  logic [3:0] tp_a[3]  = '{4'h1, 4'h1, 4'h9};
  logic [3:0] tp_b[3]  = '{4'h1, 4'h1, 4'h1};
  logic [3:0] tp_y[3]  = '{4'b0010, 4'b0000, 4'b1100};

  initial begin
    int i, n, nlog;
    bit acc;
    #32 rst_n = 1'b1;
    @(negedge clk);
    chk(cmd_ready == 1'b1, "reset_ready", 32'(cmd_ready), 32'd1);
    chk(rsp_valid == 1'b0, "reset_valid", 32'(rsp_valid), 32'd0);
    chk(alu_a == 4'h0, "reset_alu_a", 32'(alu_a), 32'd0);

    // Add 1+1: operands one edge after accept, response on the second edge
    cmd_opcode = 4'h0; cmd_a = 4'h1; cmd_b = 4'h1; cmd_cin = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk(alu_a == 4'h1 && alu_b == 4'h1 && alu_opcode == 4'h0, "t1_alu_load",
        32'({alu_opcode, alu_a, alu_b}), 32'h011);
    chk(rsp_valid == 1'b0, "t1_valid_e1", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk(rsp_valid == 1'b0, "t1_valid_e2", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk(rsp_valid == 1'b1, "t1_valid_e3", 32'(rsp_valid), 32'd1);
    chk(rsp_y == 4'b0010, "t1_y", 32'(rsp_y), 32'h2);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk(rsp_valid == 1'b0, "t1_consumed", 32'(rsp_valid), 32'd0);

    // Subtract to zero, then ASR held for 5 cycles, then an undefined opcode
    do_cmd(4'h1, 4'h1, 4'h1, 1'b0, 0, 4'b0000, 4'b0001);
    do_cmd(4'h2, 4'b1001, 4'b0001, 1'b0, 5, 4'b1100, 4'b0010);
    do_cmd(4'hF, 4'h6, 4'h3, 1'b1, 1, 4'h6, 4'b0000);

    // Reset during HOLD aborts the command
    nlog = log_y.size();
    @(negedge clk);
    cmd_opcode = 4'h5; cmd_a = 4'h3; cmd_b = 4'h4; cmd_valid = 1'b1;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk(alu_a == 4'h0 && alu_b == 4'h0 && alu_opcode == 4'h0, "rst_alu_clear",
        32'({alu_opcode, alu_a, alu_b}), 32'h0);
    chk(rsp_valid == 1'b0, "rst_valid", 32'(rsp_valid), 32'd0);
    chk(rsp_y == 4'h0, "rst_rsp_y", 32'(rsp_y), 32'd0);
    chk(busy == 1'b0, "rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk(log_y.size() == nlog, "rst_no_rsp", 32'(log_y.size()), 32'(nlog));
    do_cmd(4'h5, 4'h3, 4'h4, 1'b0, 0, 4'h7, 4'b0000);

    // Back-to-back commands with cmd_valid and rsp_ready held high
    log_y.delete(); log_c.delete();
    @(negedge clk);
    rsp_ready = 1'b1;
    i = 0;
    cmd_opcode = tp_op[0]; cmd_a = tp_a[0]; cmd_b = tp_b[0]; cmd_cin = 1'b0;
    cmd_valid = 1'b1;
    n = 0;
    while (i < 3 && n < 60) begin
      acc = cmd_ready;
      @(negedge clk);
      n++;
      if (acc) begin
        i++;
        if (i < 3) begin
          cmd_opcode = tp_op[i]; cmd_a = tp_a[i]; cmd_b = tp_b[i];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    chk(i == 3, "tp_accept_timeout", 32'(i), 32'd3);
    n = 0;
    while (log_y.size() < 3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    rsp_ready = 1'b0;
    chk(log_y.size() == 3, "tp_count", 32'(log_y.size()), 32'd3);
    if (log_y.size() == 3) begin
      for (int k = 0; k < 3; k++)
        chk(log_y[k] == tp_y[k], "tp_y", 32'(log_y[k]), 32'(tp_y[k]));
      chk(log_c[1] - log_c[0] == SETTLE + 2, "tp_gap01", 32'(log_c[1] - log_c[0]), 32'(SETTLE + 2));
      chk(log_c[2] - log_c[1] == SETTLE + 2, "tp_gap12", 32'(log_c[2] - log_c[1]), 32'(SETTLE + 2));
    end

`ifdef ALU_SEQ_STICKY_EN
    @(negedge clk);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    chk(sticky_flags == 4'b0000, "sticky_cleared", 32'(sticky_flags), 32'h0);
    do_cmd(4'h1, 4'h1, 4'h1, 1'b0, 0, 4'b0000, 4'b0001);
    do_cmd(4'h2, 4'b1001, 4'b0001, 1'b0, 0, 4'b1100, 4'b0010);
    chk(sticky_flags == 4'b0011, "sticky_accum", 32'(sticky_flags), 32'h3);
    @(negedge clk);
    cmd_opcode = 4'h1; cmd_a = 4'h1; cmd_b = 4'h1; cmd_cin = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    chk(rsp_valid == 1'b1, "sticky_cap_valid", 32'(rsp_valid), 32'd1);
    chk(sticky_flags == 4'b0000, "sticky_clr_wins", 32'(sticky_flags), 32'h0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
